// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
//   Rate-codes one sample of 16 four-bit channel intensities into N_FRAMES
//   spike frames, each held for 16 clock cycles. A channel spikes in a frame
//   when its intensity beats a per-frame pseudo-random value, so the spike
//   count over a sample is roughly proportional to the intensity.
//
//   Optional build macro SPIKE_ENC_DETERMINISTIC_EN: replaces the LFSR path
//   with 16 per-channel 4-bit phase accumulators. In this mode a channel
//   spikes on the carry-out of acc + intensity, which gives an evenly spaced
//   spike train. The default build (macro undefined) uses the LFSR.
//
// Parameters
//   N_FRAMES            frames per accepted sample (1..256)
// Ports
//   clock               single clock, posedge
//   reset               synchronous, active-low
//   in_valid/in_ready   sample handshake; in_ready is high only while idle
//   in_intensity[63:0]  channel k intensity at bits [4k+3:4k]
//   in_ein[15:0]        per-channel excitatory(1)/inhibitory(0) flag
//   parallel_spike_in   current spike frame, bit k = channel k
//   parallel_Ein        in_ein latched at the last accept
//   frame_strobe        pulse in the first cycle of every frame
//   sample_done         pulse in the cycle after the last frame ends
//   busy                high while frames are being presented
module spike_rate_encoder #(
  parameter int N_FRAMES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_intensity,
  input  logic [15:0] in_ein,
  output logic [15:0] parallel_spike_in,
  output logic [15:0] parallel_Ein,
  output logic        frame_strobe,
  output logic        sample_done,
  output logic        busy
);

  localparam logic [7:0] LAST_FRAME = 8'(N_FRAMES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cycle_cnt_reg;
  logic [7:0]  frame_cnt_reg;
  logic [63:0] intensity_reg;
  logic [15:0] ein_reg;
  logic [15:0] spike_reg;
  logic        strobe_reg;
  logic        done_reg;

  logic        accept;
  logic        last_cycle;
  logic        last_frame;
  logic        gen_frame;
  logic        end_sample;
  logic [63:0] int_src;
  logic [15:0] spike_gen;

  assign accept     = in_valid && (state_reg == IDLE);
  assign last_cycle = (cycle_cnt_reg == 4'd15);
  assign last_frame = (frame_cnt_reg == LAST_FRAME);
  // Frame 0 is produced on the accept edge itself, later frames on the
  // edge that closes the previous frame.
  assign gen_frame  = accept || ((state_reg == RUN) && last_cycle && !last_frame);
  assign end_sample = (state_reg == RUN) && last_cycle && last_frame;
  // On the accept edge the intensities are not latched yet, so frame 0
  // is computed straight from the input bus.
  assign int_src    = accept ? in_intensity : intensity_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)     state_next = RUN;
      RUN:     if (end_sample) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SPIKE_ENC_DETERMINISTIC_EN
  // Phase accumulators: the accept edge starts from zero, which clears them.
  for (genvar gi = 0; gi < 16; gi++) begin : g_acc
    logic [3:0] acc_reg;
    logic [4:0] sum;
    assign sum = {1'b0, (accept ? 4'd0 : acc_reg)} + {1'b0, int_src[4*gi +: 4]};
    assign spike_gen[gi] = sum[4];
    always_ff @(posedge clock) begin
      if (!reset)
        acc_reg <= '0;
      else if (gen_frame)
        acc_reg <= sum[3:0];
    end
  end
`else
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form: taps at bits
  // 0,2,3,5 feed bit 15. Advances only when a frame is generated.
  logic [15:0] lfsr_reg;

  always_ff @(posedge clock) begin
    if (!reset)
      lfsr_reg <= 16'hACE1;
    else if (gen_frame)
      lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
  end

  // Channel k compares against a 4-bit window of the LFSR starting at bit k.
  for (genvar gi = 0; gi < 16; gi++) begin : g_cmp
    logic [3:0] rnd;
    assign rnd = {lfsr_reg[(gi + 3) % 16], lfsr_reg[(gi + 2) % 16],
                  lfsr_reg[(gi + 1) % 16], lfsr_reg[gi]};
    assign spike_gen[gi] = int_src[4*gi +: 4] > rnd;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cycle_cnt_reg <= '0;
      frame_cnt_reg <= '0;
      intensity_reg <= '0;
      ein_reg       <= '0;
      spike_reg     <= '0;
      strobe_reg    <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      strobe_reg <= gen_frame;
      done_reg   <= end_sample;

      if (accept) begin
        intensity_reg <= in_intensity;
        ein_reg       <= in_ein;
      end

      if (gen_frame)
        spike_reg <= spike_gen;
      else if (end_sample)
        spike_reg <= '0;

      if (accept) begin
        cycle_cnt_reg <= '0;
        frame_cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        cycle_cnt_reg <= cycle_cnt_reg + 4'd1;
        if (last_cycle)
          frame_cnt_reg <= last_frame ? 8'd0 : frame_cnt_reg + 8'd1;
      end
    end
  end

  assign in_ready          = (state_reg == IDLE);
  assign busy              = (state_reg == RUN);
  assign parallel_spike_in = spike_reg;
  assign parallel_Ein      = ein_reg;
  assign frame_strobe      = strobe_reg;
  assign sample_done       = done_reg;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder. A cycle-level model driven by "cycles since
// accept" produces the expected outputs, checked every cycle; directed
// scenarios add hand-computed literal checks.
module tb_spike_rate_encoder;

`ifdef SPIKE_ENC_DETERMINISTIC_EN
  localparam int NF = 4;
  localparam logic [63:0] INT_A   = 64'h8888_8888_8888_8888;
  localparam logic [15:0] FRAME0A = 16'h0000;
`else
  localparam int NF = 256;
  // ch0 = 0, ch1..ch14 = 8, ch15 = 15; with LFSR 16'hACE1 frame 0 is 16'hCA62.
  localparam logic [63:0] INT_A   = 64'hF888_8888_8888_8880;
  localparam logic [15:0] FRAME0A = 16'hCA62;
`endif
  localparam logic [63:0] INT_B = 64'h0F1E_2D3C_4B5A_6978;
  localparam logic [63:0] INT_C = 64'h3C0F_A5E1_7B29_D046;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_intensity = '0;
  logic [15:0] in_ein = '0;
  logic        in_ready, frame_strobe, sample_done, busy;
  logic [15:0] parallel_spike_in, parallel_Ein;

  spike_rate_encoder #(.N_FRAMES(NF)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_intensity(in_intensity), .in_ein(in_ein),
    .parallel_spike_in(parallel_spike_in), .parallel_Ein(parallel_Ein),
    .frame_strobe(frame_strobe), .sample_done(sample_done), .busy(busy)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid = 1'b0;
  bit          m_active;
  int          m_t;
  logic [15:0] m_frame, m_ein, m_lfsr;
  logic [63:0] m_int;
  bit          m_strobe, m_done;
  int          m_acc [16];

  function automatic logic [15:0] next_frame();
    logic [15:0] f;
    int unsigned l, r, ik, s;
    f = '0;
    l = m_lfsr;
    for (int k = 0; k < 16; k++) begin
      ik = m_int[4*k +: 4];
`ifdef SPIKE_ENC_DETERMINISTIC_EN
      s = m_acc[k] + ik;
      f[k] = (s >= 16);
      m_acc[k] = s % 16;
`else
      r = ((l >> k) | (l << (16 - k))) & 32'd15;
      f[k] = (ik > r);
`endif
    end
    m_lfsr = (m_lfsr >> 1) | (16'((l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1) << 15);
    return f;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_valid = 1'b1; m_active = 1'b0; m_t = 0;
      m_frame = '0; m_ein = '0; m_lfsr = 16'hACE1; m_int = '0;
      m_strobe = 1'b0; m_done = 1'b0;
      for (int k = 0; k < 16; k++) m_acc[k] = 0;
    end else begin
      m_strobe = 1'b0; m_done = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == 16 * NF) begin
          m_active = 1'b0; m_frame = '0; m_done = 1'b1;
        end else if (m_t % 16 == 0) begin
          m_frame = next_frame(); m_strobe = 1'b1;
        end
      end else if (in_valid) begin
        m_int = in_intensity; m_ein = in_ein; m_active = 1'b1; m_t = 0;
        for (int k = 0; k < 16; k++) m_acc[k] = 0;
        m_frame = next_frame(); m_strobe = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("model_in_ready", 32'(in_ready), 32'(!m_active));
      check("model_busy", 32'(busy), 32'(m_active));
      check("model_spike", 32'(parallel_spike_in), 32'(m_frame));
      check("model_ein", 32'(parallel_Ein), 32'(m_ein));
      check("model_strobe", 32'(frame_strobe), 32'(m_strobe));
      check("model_done", 32'(sample_done), 32'(m_done));
    end
  end

  // ---------------- directed scenarios ----------------
  logic [15:0] seen [4];

  task automatic start_sample(input logic [63:0] inten, input logic [15:0] ein, input bit hold);
    in_intensity = inten;
    in_ein = ein;
    in_valid = 1'b1;
    @(negedge clock);
    check("accept_strobe", 32'(frame_strobe), 32'd1);
    check("accept_busy", 32'(busy), 32'd1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic run_until_done(input int poke, output int strobes, output logic [15:0] or_spk);
    int cyc;
    bit done_seen;
    cyc = 0; done_seen = 1'b0; strobes = 1;
    or_spk = parallel_spike_in;
    seen[0] = parallel_spike_in;
    while (!done_seen && cyc <= 16 * NF + 4) begin
      @(negedge clock);
      cyc++;
      if (cyc == poke) begin
        in_valid = 1'b1;
        in_intensity = ~in_intensity;
        in_ein = ~in_ein;
        check("busy_in_ready", 32'(in_ready), 32'd0);
      end
      if (cyc == poke + 2) in_valid = 1'b0;
      if (frame_strobe) begin
        strobes++;
        check("strobe_spacing", 32'(cyc % 16), 32'd0);
        if (strobes <= 4) seen[strobes-1] = parallel_spike_in;
      end
      or_spk |= parallel_spike_in;
      if (sample_done) begin
        done_seen = 1'b1;
        check("done_latency", 32'(cyc), 32'(16 * NF));
      end
    end
    if (!done_seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no sample_done within %0d cycles", cyc);
    end
  endtask

  initial begin
    int strobes;
    logic [15:0] or_spk;

    // Reset for 3 cycles with in_valid asserted: it must be ignored.
    reset = 1'b0; in_valid = 1'b1; in_intensity = INT_B; in_ein = 16'hFFFF;
    repeat (3) @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_spike", 32'(parallel_spike_in), 32'd0);
    check("rst_ein", 32'(parallel_Ein), 32'd0);
    check("rst_strobe", 32'(frame_strobe), 32'd0);
    check("rst_done", 32'(sample_done), 32'd0);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Sample 1: fresh from reset, with a busy-time accept attempt.
    start_sample(INT_A, 16'h00FF, 1'b0);
    check("frame0_fresh", 32'(parallel_spike_in), 32'(FRAME0A));
    check("ein_latched", 32'(parallel_Ein), 32'h00FF);
    run_until_done(20, strobes, or_spk);
    check("strobe_count", 32'(strobes), 32'(NF));
    check("ein_after_poke", 32'(parallel_Ein), 32'h00FF);
    check("done_in_ready", 32'(in_ready), 32'd1);
`ifdef SPIKE_ENC_DETERMINISTIC_EN
    check("det_frame0", 32'(seen[0]), 32'h0000);
    check("det_frame1", 32'(seen[1]), 32'hFFFF);
    check("det_frame2", 32'(seen[2]), 32'h0000);
    check("det_frame3", 32'(seen[3]), 32'hFFFF);
`else
    check("ch0_silent", 32'(or_spk[0]), 32'd0);
    check("ch15_fires", 32'(or_spk[15]), 32'd1);
`endif
    repeat (3) @(negedge clock);
    check("idle_ein_hold", 32'(parallel_Ein), 32'h00FF);

    // Mid-sample reset during frame 2.
    start_sample(INT_B, 16'h1234, 1'b0);
    repeat (16 * 2 + 3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_spike", 32'(parallel_spike_in), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_done", 32'(sample_done), 32'd0);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clock);
      check("midrst_no_done", 32'(sample_done), 32'd0);
    end
    start_sample(INT_A, 16'h00FF, 1'b0);
    check("frame0_after_rst", 32'(parallel_spike_in), 32'(FRAME0A));
    run_until_done(-10, strobes, or_spk);
    check("strobe_count2", 32'(strobes), 32'(NF));

    // Back-to-back: in_valid held high across two samples.
    start_sample(INT_B, 16'hA5A5, 1'b1);
    in_intensity = INT_C; in_ein = 16'h5A5A;
    run_until_done(-10, strobes, or_spk);
    @(negedge clock);
    check("b2b_strobe", 32'(frame_strobe), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_ein", 32'(parallel_Ein), 32'h5A5A);
    in_valid = 1'b0;
    run_until_done(-10, strobes, or_spk);
    check("b2b_strobe_count", 32'(strobes), 32'(NF));

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
